// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing with a one-pixel look-ahead
// board-cell address for a synchronous colour RAM.
// Optional build macro PIXEL_DIV_EN: clk is 50 MHz and pixel_en is derived
// from a 1-bit phase register; when undefined, clk is the 25 MHz pixel clock.
module vga_timing_gen #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BOARD_X0 = 220,
  parameter int BOARD_Y0 = 40,
  parameter int CELL_PX  = 20,
  parameter int BOARD_W  = 10,
  parameter int BOARD_H  = 20
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_en,
  output logic [9:0] column,
  output logic [8:0] row,
  output logic       blank_n,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       frame_tick,
  output logic [7:0] cell_addr,
  output logic       cell_valid
);

  localparam logic [9:0] H_MAX   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VEND  = 10'(H_VIS);
  localparam logic [9:0] H_S0    = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_S1    = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_VEND  = 10'(V_VIS);
  localparam logic [9:0] V_S0    = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_S1    = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] BX0     = 10'(BOARD_X0);
  localparam logic [9:0] BX1     = 10'(BOARD_X0 + BOARD_W * CELL_PX);
  localparam logic [9:0] BY0     = 10'(BOARD_Y0);
  localparam logic [9:0] BY1     = 10'(BOARD_Y0 + BOARD_H * CELL_PX);
  localparam logic [4:0] SUB_MAX = 5'(CELL_PX - 1);
  localparam logic [3:0] CX_MAX  = 4'(BOARD_W - 1);
  localparam logic [4:0] CY_MAX  = 5'(BOARD_H - 1);

  logic [9:0] r_h, r_v, w_h_nx, w_v_nx;
  logic [4:0] r_sx, w_sx_nx, r_sy, w_sy_nx, r_cy, w_cy_nx;
  logic [3:0] r_cx, w_cx_nx;
  logic       w_in_board_nx;
  logic [7:0] w_addr_nx;

`ifdef PIXEL_DIV_EN
  logic r_phase;

  // Divide the 50 MHz clock by two: pixel_en is high on every second clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_phase <= 1'b0;
    else       r_phase <= ~r_phase;
  end

  assign pixel_en = r_phase;
`else
  assign pixel_en = 1'b1;
`endif

  // Next raster position and next sub/cell counters (they track the current h,v).
  always_comb begin
    w_h_nx  = r_h;
    w_v_nx  = r_v;
    w_sx_nx = r_sx;
    w_cx_nx = r_cx;
    w_sy_nx = r_sy;
    w_cy_nx = r_cy;
    if (r_h == H_MAX) begin
      w_h_nx  = 10'd0;
      w_sx_nx = 5'd0;
      w_cx_nx = 4'd0;
      if (r_v == V_MAX) begin
        w_v_nx  = 10'd0;
        w_sy_nx = 5'd0;
        w_cy_nx = 5'd0;
      end else begin
        w_v_nx = r_v + 10'd1;
        if (r_v >= BY0 && r_v < BY1) begin
          if (r_sy == SUB_MAX) begin
            w_sy_nx = 5'd0;
            w_cy_nx = (r_cy == CY_MAX) ? 5'd0 : r_cy + 5'd1;
          end else begin
            w_sy_nx = r_sy + 5'd1;
          end
        end
      end
    end else begin
      w_h_nx = r_h + 10'd1;
      if (r_h >= BX0 && r_h < BX1) begin
        if (r_sx == SUB_MAX) begin
          w_sx_nx = 5'd0;
          w_cx_nx = (r_cx == CX_MAX) ? 4'd0 : r_cx + 4'd1;
        end else begin
          w_sx_nx = r_sx + 5'd1;
        end
      end
    end
  end

  // Cell index of the position the counters move to: cell_y*10 as (y<<3)+(y<<1).
  assign w_in_board_nx = (w_h_nx >= BX0) && (w_h_nx < BX1) &&
                         (w_v_nx >= BY0) && (w_v_nx < BY1);
  assign w_addr_nx = {w_cy_nx, 3'b000} + {2'b00, w_cy_nx, 1'b0} + {4'b0000, w_cx_nx};

  // Raster and cell counters advance once per pixel_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h  <= 10'd0;
      r_v  <= 10'd0;
      r_sx <= 5'd0;
      r_cx <= 4'd0;
      r_sy <= 5'd0;
      r_cy <= 5'd0;
    end else if (pixel_en) begin
      r_h  <= w_h_nx;
      r_v  <= w_v_nx;
      r_sx <= w_sx_nx;
      r_cx <= w_cx_nx;
      r_sy <= w_sy_nx;
      r_cy <= w_cy_nx;
    end
  end

  // Registered outputs: decode of the pre-increment position, cell data one pixel ahead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      column     <= 10'd0;
      row        <= 9'd0;
      blank_n    <= 1'b0;
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
      frame_tick <= 1'b0;
      cell_addr  <= 8'd0;
      cell_valid <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (pixel_en) begin
        column     <= r_h;
        row        <= r_v[8:0];
        blank_n    <= (r_h < H_VEND) && (r_v < V_VEND);
        hsync_n    <= !((r_h >= H_S0) && (r_h < H_S1));
        vsync_n    <= !((r_v >= V_S0) && (r_v < V_S1));
        frame_tick <= (r_h == 10'd0) && (r_v == V_VEND);
        cell_addr  <= w_in_board_nx ? w_addr_nx : 8'd0;
        cell_valid <= w_in_board_nx;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: full-size instance plus a scaled-down instance so that
// whole frames fit in a short run; both are compared with an arithmetic model.
module tb_vga_timing_gen;

  typedef struct packed {
    int hvis; int hfp; int hsync; int hbp;
    int vvis; int vfp; int vsync; int vbp;
    int bx; int by; int cp; int bw; int bh;
  } cfg_t;

`ifdef PIXEL_DIV_EN
  localparam int EXP_FIRST = 2;
`else
  localparam int EXP_FIRST = 1;
`endif

  localparam logic [31:0] RST_VEC = {10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};

  logic clk = 1'b0;
  logic reset;
  logic pe_b, bl_b, hs_b, vs_b, ft_b, cv_b;
  logic [9:0] col_b;
  logic [8:0] row_b;
  logic [7:0] ca_b;
  logic pe_s, bl_s, hs_s, vs_s, ft_s, cv_s;
  logic [9:0] col_s;
  logic [8:0] row_s;
  logic [7:0] ca_s;
  logic [31:0] obs_b, obs_s;

  cfg_t CB, CS;
  int   k;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_b (
    .clk(clk), .reset(reset), .pixel_en(pe_b), .column(col_b), .row(row_b),
    .blank_n(bl_b), .hsync_n(hs_b), .vsync_n(vs_b), .frame_tick(ft_b),
    .cell_addr(ca_b), .cell_valid(cv_b)
  );

  vga_timing_gen #(
    .H_VIS(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_VIS(16), .V_FP(3), .V_SYNC(2), .V_BP(4),
    .BOARD_X0(6), .BOARD_Y0(3), .CELL_PX(2), .BOARD_W(10), .BOARD_H(4)
  ) dut_s (
    .clk(clk), .reset(reset), .pixel_en(pe_s), .column(col_s), .row(row_s),
    .blank_n(bl_s), .hsync_n(hs_s), .vsync_n(vs_s), .frame_tick(ft_s),
    .cell_addr(ca_s), .cell_valid(cv_s)
  );

  assign obs_b = {col_b, row_b, bl_b, hs_b, vs_b, ft_b, ca_b, cv_b};
  assign obs_s = {col_s, row_s, bl_s, hs_s, vs_s, ft_s, ca_s, cv_s};

  // Expected outputs after k pixel updates: the presented pixel is raster index
  // k-1, the cell outputs describe raster index k. en says whether this clk updated.
  function automatic logic [31:0] model(input cfg_t c, input int kk, input bit en);
    int htot, vtot, p, h, v, hh, vv;
    bit inb;
    logic [31:0] r;
    if (kk == 0) return RST_VEC;
    htot = c.hvis + c.hfp + c.hsync + c.hbp;
    vtot = c.vvis + c.vfp + c.vsync + c.vbp;
    p  = kk - 1;
    h  = p % htot;
    v  = (p / htot) % vtot;
    hh = kk % htot;
    vv = (kk / htot) % vtot;
    inb = (hh >= c.bx) && (hh < c.bx + c.bw * c.cp) && (vv >= c.by) && (vv < c.by + c.bh * c.cp);
    r[31:22] = 10'(h);
    r[21:13] = 9'(v % 512);
    r[12]    = (h < c.hvis) && (v < c.vvis);
    r[11]    = !((h >= c.hvis + c.hfp) && (h < c.hvis + c.hfp + c.hsync));
    r[10]    = !((v >= c.vvis + c.vfp) && (v < c.vvis + c.vfp + c.vsync));
    r[9]     = en && (h == 0) && (v == c.vvis);
    r[8:1]   = inb ? 8'(((vv - c.by) / c.cp) * c.bw + (hh - c.bx) / c.cp) : 8'd0;
    r[0]     = inb;
    return r;
  endfunction

  // One clk; reports whether it was a pixel update.
  task automatic step(output bit en);
    @(posedge clk);
    en = pe_b;
    #1;
    if (en) k++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (obs_b !== RST_VEC) begin n_fail++; $display("FAIL reset_big: got %h, expected %h", obs_b, RST_VEC); end
    n_checks++;
    if (obs_s !== RST_VEC) begin n_fail++; $display("FAIL reset_small: got %h, expected %h", obs_s, RST_VEC); end
    repeat ($urandom_range(2, 5)) @(posedge clk);
    #1;
    n_checks++;
    if (obs_b !== RST_VEC) begin n_fail++; $display("FAIL reset_hold: got %h, expected %h", obs_b, RST_VEC); end
    @(negedge clk);
    reset = 1'b0;
    k = 0;
  endtask

  task automatic test_first_pixel();
    int clks = 0;
    bit en = 1'b0;
    logic [31:0] e;
    while (!en && clks < 6) begin step(en); clks++; end
    n_checks++;
    if (clks != EXP_FIRST || !en) begin n_fail++; $display("FAIL first_pe_latency: got %0d clks, expected %0d", clks, EXP_FIRST); end
    n_checks++;
    if ({col_b, row_b, bl_b} !== {10'd0, 9'd0, 1'b1}) begin
      n_fail++; $display("FAIL first_pixel: got col=%0d row=%0d blank_n=%b, expected 0 0 1", col_b, row_b, bl_b);
    end
    e = model(CB, k, en);
    n_checks++;
    if (obs_b !== e) begin n_fail++; $display("FAIL first_state_big: got %h, expected %h", obs_b, e); end
    e = model(CS, k, en);
    n_checks++;
    if (obs_s !== e) begin n_fail++; $display("FAIL first_state_small: got %h, expected %h", obs_s, e); end
  endtask

  task automatic test_line();
    int clks = 0, nb = 0, nh = 0, hmin = 9999, hmax = -1;
    bit en;
    logic [31:0] e;
    while (k < 801 && clks < 4000) begin
      step(en); clks++;
      e = model(CB, k, en);
      n_checks++;
      if (obs_b !== e) begin n_fail++; $display("FAIL line_state: got %h, expected %h (k=%0d)", obs_b, e, k); end
      if (en) begin
        if (bl_b) nb++;
        if (!hs_b) begin
          nh++;
          if (int'(col_b) < hmin) hmin = int'(col_b);
          if (int'(col_b) > hmax) hmax = int'(col_b);
        end
      end
    end
    n_checks++;
    if (k < 801) begin n_fail++; $display("FAIL line_timeout: got k=%0d, expected 801", k); end
    n_checks++;
    if (nb != 640) begin n_fail++; $display("FAIL line_blank_count: got %0d, expected 640", nb); end
    n_checks++;
    if (nh != 96 || hmin != 656 || hmax != 751) begin
      n_fail++; $display("FAIL line_hsync: got n=%0d cols %0d..%0d, expected 96 cols 656..751", nh, hmin, hmax);
    end
  endtask

  task automatic test_board();
    int clks = 0, spots = 0, bad = 0;
    int q[$];
    bit en;
    logic [31:0] e;
    while (k < 48801 && clks < 100000) begin
      step(en); clks++;
      e = model(CB, k, en);
      n_checks++;
      if (obs_b !== e) begin n_fail++; $display("FAIL board_state: got %h, expected %h (k=%0d)", obs_b, e, k); end
      if (en && row_b == 9'd40) begin
        case (col_b)
          10'd218: begin spots++; n_checks++;
            if (cv_b !== 1'b0) begin n_fail++; $display("FAIL cell_before_219: got valid=%b, expected 0", cv_b); end end
          10'd219: begin spots++; n_checks++;
            if ({ca_b, cv_b} !== {8'd0, 1'b1}) begin n_fail++; $display("FAIL cell_at_220: got addr=%0d valid=%b, expected 0 1", ca_b, cv_b); end end
          10'd238: begin spots++; n_checks++;
            if (ca_b !== 8'd0) begin n_fail++; $display("FAIL cell_at_239: got %0d, expected 0", ca_b); end end
          10'd239: begin spots++; n_checks++;
            if (ca_b !== 8'd1) begin n_fail++; $display("FAIL cell_at_240: got %0d, expected 1", ca_b); end end
          10'd418: begin spots++; n_checks++;
            if ({ca_b, cv_b} !== {8'd9, 1'b1}) begin n_fail++; $display("FAIL cell_at_419: got addr=%0d valid=%b, expected 9 1", ca_b, cv_b); end end
          10'd419: begin spots++; n_checks++;
            if (cv_b !== 1'b0) begin n_fail++; $display("FAIL cell_at_420: got valid=%b, expected 0", cv_b); end end
          default: ;
        endcase
      end
      if (en && row_b == 9'd60 && cv_b) q.push_back(int'(ca_b));
    end
    n_checks++;
    if (k < 48801) begin n_fail++; $display("FAIL board_timeout: got k=%0d, expected 48801", k); end
    n_checks++;
    if (spots != 6) begin n_fail++; $display("FAIL board_spots_seen: got %0d, expected 6", spots); end
    foreach (q[i]) if (q[i] != 10 + i / 20) bad++;
    n_checks++;
    if (q.size() != 200 || bad != 0) begin
      n_fail++; $display("FAIL row60_seq: got %0d values with %0d wrong, expected 200 with 0 wrong", q.size(), bad);
    end
  endtask

  task automatic test_small_frame();
    int k0 = k, clks = 0, nv = 0, vbad = 0, wbad = 0, tbad = 0;
    int tk[$];
    bit en;
    logic ft_prev = 1'b0;
    logic [31:0] e;
    while (k < k0 + 2400 && clks < 6000) begin
      step(en); clks++;
      e = model(CS, k, en);
      n_checks++;
      if (obs_s !== e) begin n_fail++; $display("FAIL small_state: got %h, expected %h (k=%0d)", obs_s, e, k); end
      if (ft_s) begin
        tk.push_back(k);
        if (col_s != 10'd0 || row_s != 9'd16) tbad++;
        if (ft_prev) wbad++;
      end
      ft_prev = ft_s;
      if (en && !vs_s) begin
        nv++;
        if (row_s != 9'd19 && row_s != 9'd20) vbad++;
      end
    end
    n_checks++;
    if (tk.size() != 2 || tbad != 0) begin n_fail++; $display("FAIL tick_count: got %0d ticks (%0d misplaced), expected 2 (0)", tk.size(), tbad); end
    n_checks++;
    if (tk.size() != 2 || tk[1] - tk[0] != 1200) begin n_fail++; $display("FAIL frame_length: got %0d ticks, expected 2 ticks 1200 apart", tk.size()); end
    n_checks++;
    if (wbad != 0) begin n_fail++; $display("FAIL tick_width: got %0d wide ticks, expected 0", wbad); end
    n_checks++;
    if (nv != 192 || vbad != 0) begin n_fail++; $display("FAIL vsync_rows: got %0d low (%0d off-row), expected 192 (0)", nv, vbad); end
  endtask

  task automatic test_midframe_reset();
    for (int it = 0; it < 3; it++) begin
      int n, clks = 0;
      bit en = 1'b0;
      logic [31:0] e;
      n = (it == 0) ? 800 * int'($urandom_range(1, 3)) + 300 : int'($urandom_range(50, 3000));
      while (k < n && clks < 8000) begin
        step(en); clks++;
        e = model(CB, k, en);
        n_checks++;
        if (obs_b !== e) begin n_fail++; $display("FAIL run_big: got %h, expected %h (k=%0d)", obs_b, e, k); end
        e = model(CS, k, en);
        n_checks++;
        if (obs_s !== e) begin n_fail++; $display("FAIL run_small: got %h, expected %h (k=%0d)", obs_s, e, k); end
      end
      #($urandom_range(1, 3));
      reset = 1'b1;
      #1;
      n_checks++;
      if (obs_b !== RST_VEC || obs_s !== RST_VEC) begin
        n_fail++; $display("FAIL async_reset: got %h/%h, expected %h", obs_b, obs_s, RST_VEC);
      end
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      n_checks++;
      if (obs_b !== RST_VEC || obs_s !== RST_VEC) begin
        n_fail++; $display("FAIL reset_held: got %h/%h, expected %h", obs_b, obs_s, RST_VEC);
      end
      @(negedge clk);
      reset = 1'b0;
      k = 0;
      clks = 0;
      en = 1'b0;
      while (!en && clks < 6) begin step(en); clks++; end
      n_checks++;
      if (!en || {col_b, row_b, bl_b} !== {10'd0, 9'd0, 1'b1}) begin
        n_fail++; $display("FAIL restart_pixel: got col=%0d row=%0d blank_n=%b, expected 0 0 1", col_b, row_b, bl_b);
      end
      e = model(CS, k, en);
      n_checks++;
      if (obs_s !== e) begin n_fail++; $display("FAIL restart_small: got %h, expected %h", obs_s, e); end
    end
  endtask

  initial begin
    reset = 1'b1;
    k = 0;
    CB = '{640, 16, 96, 48, 480, 10, 2, 33, 220, 40, 20, 10, 20};
    CS = '{32, 4, 6, 6, 16, 3, 2, 4, 6, 3, 2, 10, 4};
    test_reset();
    test_first_pixel();
    test_line();
    test_board();
    test_small_frame();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
